rca_pipe: RTL and testbench
===========================

Name: rca_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit ripple-carry adder: WIDTH-bit add/subtract split into STAGES ripple segments, one register boundary per segment.
- Carry is registered between segments; operand skew registers align segment inputs and outputs.
- Throughput is one operation per cycle with a valid/ready handshake on both sides.
- Serves as the arithmetic core for wider datapaths where a flat 32/64-bit ripple chain misses timing.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of ripple segments; range 1..WIDTH.
- SEG_W, WIDTH/STAGES, derived segment width; not overridable.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- In_Valid  input  1  operand beat valid.
- In_Ready  output  1  block accepts a beat this cycle.
- X  input  WIDTH  operand A.
- Y  input  WIDTH  operand B.
- Cin  input  1  carry-in; ignored when Sub=1.
- Sub  input  1  0: X+Y+Cin; 1: X-Y, computed as X+~Y+1.
- Out_Valid  output  1  result valid.
- Out_Ready  input  1  downstream accepts the result.
- Sum  output  WIDTH  result, modulo 2^WIDTH.
- Cout  output  1  carry out of the MSB; for Sub=1, 1 means no borrow.
- Ovf  output  1  signed overflow; present only with RCA_PIPE_OVF_EN.

Behaviour:
- Reset is synchronous and active-high on RST; single clock CLK.
- RST=1 at an edge clears all stage valid bits, Out_Valid, Sum, Cout and Ovf to 0. In-flight operations are discarded with no partial output.
- While RST=1, In_Ready=0.
- advance = !Out_Valid || Out_Ready; In_Ready = advance and !RST.
  - Accept occurs when In_Valid && In_Ready.
  - On advance, every stage shifts one position. An empty input cycle inserts a bubble (valid=0).
  - When advance=0, the whole pipeline holds. Sum, Cout and Ovf stay stable while Out_Valid && !Out_Ready.
- Stage k (k=0..STAGES-1):
  - Adds segment k of X and effective Y: Y, or ~Y when Sub=1.
  - Carry-in is the registered carry from stage k-1. For stage 0, carry-in is Cin, or 1 when Sub=1.
  - The stage registers its segment sum, carry and the remaining upper operand segments.
  - Lower sum segments already computed ride along in skew registers.
- Latency is exactly STAGES cycles from accept to Out_Valid, with no stalls. Each stall cycle adds one cycle.
- The Sub bit travels with its beat, so mixed add/sub back-to-back is legal.
- Simultaneous accept and output handshake in the same cycle is legal and sustains full throughput.
- STAGES=1 degenerates to a registered flat adder with one-cycle latency.
- Out_Valid is never dropped without an Out_Ready handshake, except by RST.

Optional Feature:
- Macro: RCA_PIPE_OVF_EN.
- Defined: port Ovf exists. Ovf = carry into MSB XOR carry out of MSB, computed in the final stage and registered with Sum. It is reset to 0 and held during stalls.
- Undefined: no Ovf port and no related logic; all other behaviour is identical.

Decomposition:
- Package rca_pkg:
  - localparam defaults for WIDTH and STAGES.
  - SEG_W derivation function.
  - A compile-time check function that WIDTH % STAGES == 0; elaboration fails on violation.
- Sub-module rca_seg: combinational SEG_W-bit ripple segment built from the existing FA cell (X, Y, Cin -> Sum, Cout). It is instantiated once per stage by generate.
- Pipeline registers, skew and handshake logic live in rca_pipe.

Test Plan (WIDTH=32, STAGES=4):
1. Carry across all segments: X=0xFFFFFFFF, Y=0x00000001, Cin=0, Sub=0, Out_Ready=1 -> Out_Valid high exactly 4 cycles later, Sum=0x00000000, Cout=1 (Ovf=0).
2. Subtract with borrow: X=5, Y=7, Sub=1, Cin=1 (ignored) -> Sum=0xFFFFFFFE, Cout=0. Then X=7, Y=5, Sub=1 -> Sum=0x00000002, Cout=1.
3. Throughput: 16 back-to-back random beats, mixed Sub, Out_Ready=1 -> 16 consecutive Out_Valid cycles starting at cycle 4, each matching reference model (X±Y+Cin) mod 2^32 and carry.
4. Backpressure: pipeline full, Out_Ready=0 for 3 cycles -> In_Ready=0 for those 3 cycles. Sum/Cout are unchanged each cycle with no beat lost or duplicated. Out_Ready=1 resumes in order.
5. Reset mid-flight: 3 beats accepted, RST=1 for one cycle -> next cycle Out_Valid=0, Sum=0, Cout=0. No stale result ever appears afterward; a fresh beat emerges 4 cycles after accept.
6. With RCA_PIPE_OVF_EN: X=0x7FFFFFFF, Y=1, Sub=0 -> Sum=0x80000000, Ovf=1, Cout=0. X=0x80000000, Y=1, Sub=1 -> Sum=0x7FFFFFFF, Ovf=1, Cout=1.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared defaults and elaboration-time geometry helpers for the pipelined ripple-carry adder.
package rca_pkg;

    localparam int RCA_WIDTH  = 32;
    localparam int RCA_STAGES = 4;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    // The adder can only be cut into equal segments, one per stage.
    function automatic bit geometry_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_fa.sv
// One-bit full adder cell; the building block of every ripple segment.
module rca_fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/rca_seg.sv
// Combinational SEG_W-bit ripple segment: a chain of full adders, carry-in to carry-out.
module rca_seg #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] x,
    input  logic [SEG_W-1:0] y,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    logic [SEG_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        rca_fa u_fa (
            .x    (x[i]),
            .y    (y[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[SEG_W];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined WIDTH-bit add/subtract, one ripple segment per stage, valid/ready on both sides.
// Define RCA_PIPE_OVF_EN to add the registered signed-overflow output Ovf.
module rca_pipe
    import rca_pkg::*;
#(
    parameter int WIDTH  = RCA_WIDTH,
    parameter int STAGES = RCA_STAGES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int SEG_W = seg_width(WIDTH, STAGES);

    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("rca_pipe: STAGES must lie in 1..WIDTH and divide WIDTH evenly");
    end

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] y_eff;

    // Operands are stored pre-shifted so the next segment always sits in the low bits;
    // the sum fills in from the top and is fully aligned after the last stage.
    logic             v_q   [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] x_q   [STAGES];
    logic [WIDTH-1:0] y_q   [STAGES];

    logic             v_nxt [STAGES];
    logic             c_nxt [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic [WIDTH-1:0] x_nxt [STAGES];
    logic [WIDTH-1:0] y_nxt [STAGES];

`ifdef RCA_PIPE_OVF_EN
    logic ovf_q;
    logic ovf_nxt;
`endif

    assign advance  = !v_q[STAGES-1] || Out_Ready;
    assign In_Ready = advance && !RST;
    assign accept   = In_Valid && In_Ready;
    assign y_eff    = Sub ? ~Y : Y;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] x_prev;
        logic [WIDTH-1:0] y_prev;
        logic [WIDTH-1:0] sum_prev;
        logic             v_prev;
        logic             seg_cin;
        logic [SEG_W-1:0] seg_x;
        logic [SEG_W-1:0] seg_y;
        logic [SEG_W-1:0] seg_sum;
        logic             seg_cout;

        if (k == 0) begin : g_first
            // Subtraction is X + ~Y + 1, so the beat's Cin is ignored when Sub is set.
            assign x_prev   = X;
            assign y_prev   = y_eff;
            assign sum_prev = '0;
            assign v_prev   = accept;
            assign seg_cin  = Sub | Cin;
        end else begin : g_next
            assign x_prev   = x_q[k-1];
            assign y_prev   = y_q[k-1];
            assign sum_prev = s_q[k-1];
            assign v_prev   = v_q[k-1];
            assign seg_cin  = c_q[k-1];
        end

        assign seg_x = x_prev[SEG_W-1:0];
        assign seg_y = y_prev[SEG_W-1:0];

        rca_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .x    (seg_x),
            .y    (seg_y),
            .cin  (seg_cin),
            .sum  (seg_sum),
            .cout (seg_cout)
        );

        assign v_nxt[k] = v_prev;
        assign c_nxt[k] = seg_cout;
        assign s_nxt[k] = (sum_prev >> SEG_W) | (WIDTH'(seg_sum) << (WIDTH - SEG_W));
        assign x_nxt[k] = x_prev >> SEG_W;
        assign y_nxt[k] = y_prev >> SEG_W;

`ifdef RCA_PIPE_OVF_EN
        // Same-sign operands producing an opposite-sign result is exactly carry-in(MSB) ^ carry-out(MSB).
        if (k == STAGES - 1) begin : g_ovf
            assign ovf_nxt = (seg_x[SEG_W-1] == seg_y[SEG_W-1]) &&
                             (seg_sum[SEG_W-1] != seg_x[SEG_W-1]);
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
`ifdef RCA_PIPE_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_nxt[k];
                c_q[k] <= c_nxt[k];
                s_q[k] <= s_nxt[k];
                x_q[k] <= x_nxt[k];
                y_q[k] <= y_nxt[k];
            end
`ifdef RCA_PIPE_OVF_EN
            ovf_q <= ovf_nxt;
`endif
        end
    end

    assign Out_Valid = v_q[STAGES-1];
    assign Sum       = s_q[STAGES-1];
    assign Cout      = c_q[STAGES-1];
`ifdef RCA_PIPE_OVF_EN
    assign Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe (WIDTH=32, STAGES=4) against an arithmetic reference model.
module tb_rca_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic              In_Valid;
    logic              In_Ready;
    logic [WIDTH-1:0]  X;
    logic [WIDTH-1:0]  Y;
    logic              Cin;
    logic              Sub;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [WIDTH-1:0]  Sum;
    logic              Cout;
`ifdef RCA_PIPE_OVF_EN
    logic              Ovf;
`endif

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } result_t;

    result_t exp_q[$];
    int      acc_q[$];
    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    bit      chk_lat = 1'b1;
    bit      prev_stall = 1'b0;
    bit      accepted = 1'b0;

    rca_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .X         (X),
        .Y         (Y),
        .Cin       (Cin),
        .Sub       (Sub),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Sum       (Sum),
        .Cout      (Cout)
`ifdef RCA_PIPE_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference: plain modular arithmetic; carry-out for subtraction means "no borrow".
    function automatic result_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic cin, input logic sub);
        result_t     r;
        logic [32:0] full;
        if (sub) begin
            r.sum  = x - y;
            r.cout = (x >= y);
            r.ovf  = (x[31] != y[31]) && (r.sum[31] != x[31]);
        end else begin
            full   = {1'b0, x} + {1'b0, y} + {32'd0, cin};
            r.sum  = full[31:0];
            r.cout = full[32];
            r.ovf  = (x[31] == y[31]) && (r.sum[31] != x[31]);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, score handshakes, then advance past the edge.
    task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic cin, input logic sub, input logic ordy, input logic rst);
        result_t e;
        int      a;
        In_Valid  = iv;
        X         = x;
        Y         = y;
        Cin       = cin;
        Sub       = sub;
        Out_Ready = ordy;
        RST       = rst;
        #3;
        cyc++;
        checkOutput("in_ready", {63'd0, In_Ready}, {63'd0, (!Out_Valid || ordy) && !rst});
        if (prev_stall && !rst)
            checkOutput("valid_held", {63'd0, Out_Valid}, 64'd1);
        if (!rst && Out_Valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("no_stale", {63'd0, Out_Valid}, 64'd0);
            end else if (ordy) begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                checkOutput("sum", {32'd0, Sum}, {32'd0, e.sum});
                checkOutput("cout", {63'd0, Cout}, {63'd0, e.cout});
`ifdef RCA_PIPE_OVF_EN
                checkOutput("ovf", {63'd0, Ovf}, {63'd0, e.ovf});
`endif
                if (chk_lat)
                    checkOutput("latency", 64'(cyc - a), 64'(STAGES));
            end else begin
                checkOutput("stall_sum", {32'd0, Sum}, {32'd0, exp_q[0].sum});
                checkOutput("stall_cout", {63'd0, Cout}, {63'd0, exp_q[0].cout});
            end
        end
        prev_stall = !rst && Out_Valid && !ordy;
        accepted = !rst && iv && In_Ready;
        if (accepted) begin
            exp_q.push_back(model(x, y, cin, sub));
            acc_q.push_back(cyc);
        end
        @(posedge CLK);
        #1;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_stall = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(2);
    endtask

    logic [WIDTH-1:0] bx [8];
    logic [WIDTH-1:0] by [8];
    logic             bc [8];
    logic             bs [8];
    int               idx;

    initial begin
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("reset_valid", {63'd0, Out_Valid}, 64'd0);
        checkOutput("reset_sum", {32'd0, Sum}, 64'd0);
        checkOutput("reset_cout", {63'd0, Cout}, 64'd0);

        $display("[TB] carry ripple through every segment");
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        $display("[TB] subtract with and without borrow");
        applyStimulus(1'b1, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'd7, 32'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();

        $display("[TB] back-to-back random beats");
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        drain();

        $display("[TB] backpressure on a full pipeline");
        chk_lat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bx[i] = $urandom;
            by[i] = $urandom;
            bc[i] = 1'($urandom);
            bs[i] = 1'($urandom);
        end
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            if (idx < 8)
                applyStimulus(1'b1, bx[idx], by[idx], bc[idx], bs[idx], !(i >= 6 && i < 9), 1'b0);
            else
                applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, !(i >= 6 && i < 9), 1'b0);
            if (accepted)
                idx++;
        end
        checkOutput("bp_all_accepted", 64'(idx), 64'd8);
        drain();
        chk_lat = 1'b1;

        $display("[TB] reset with beats in flight");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("flush_valid", {63'd0, Out_Valid}, 64'd0);
        checkOutput("flush_sum", {32'd0, Sum}, 64'd0);
        checkOutput("flush_cout", {63'd0, Cout}, 64'd0);
        idle(6);
        applyStimulus(1'b1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();

`ifdef RCA_PIPE_OVF_EN
        $display("[TB] signed overflow cases");
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
